// File: rtl/pe_conv_pkg.sv
// Shared types and constants for the multi-filter 1-D convolution PE.
package pe_conv_pkg;

    // Default parameter values for the PE and its interface.
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_NUM_FILT     = 2;
    localparam int DEF_MAX_FILT_LEN = 16;
    localparam int DEF_MAX_IF_LEN   = 32;
    localparam int DEF_PSUM_W       = 20;

    // Control FSM states, also exposed on the debug port.
    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILT,
        LOAD_IF,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width of an index into n entries (never less than one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_conv_multifilt_if.sv
// Configuration, load, partial-sum and result ports of the convolution PE.
//
// Every valid/ready pair follows the same rule: a word moves on the rising
// edge where both valid and ready are high. The producer keeps valid and its
// data stable until that edge and never waits for ready before raising valid;
// the consumer may raise ready without waiting for valid.
interface pe_conv_multifilt_if
    import pe_conv_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_FILT     = DEF_NUM_FILT,
    parameter int MAX_FILT_LEN = DEF_MAX_FILT_LEN,
    parameter int MAX_IF_LEN   = DEF_MAX_IF_LEN,
    parameter int PSUM_W       = DEF_PSUM_W
);
    localparam int FLW = cnt_w(MAX_FILT_LEN);
    localparam int ILW = cnt_w(MAX_IF_LEN);
    localparam int FIW = idx_w(NUM_FILT);

    logic              start;
    logic [FLW-1:0]    filt_len;
    logic [ILW-1:0]    if_len;
    logic [ILW-1:0]    stride;
    logic              psum_mode;
    logic              filt_valid;
    logic              filt_ready;
    logic [DATA_W-1:0] filt_data;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_data;
    logic              inpsum_valid;
    logic              inpsum_ready;
    logic [PSUM_W-1:0] inpsum_data;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_data;
    logic [FIW-1:0]    out_filt;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, filt_len, if_len, stride, psum_mode,
        output filt_valid, filt_data, if_valid, if_data,
        output inpsum_valid, inpsum_data, out_ready,
        input  filt_ready, if_ready, inpsum_ready,
        input  out_valid, out_data, out_filt, out_last, busy, done, err
    );

    modport slave (
        input  start, filt_len, if_len, stride, psum_mode,
        input  filt_valid, filt_data, if_valid, if_data,
        input  inpsum_valid, inpsum_data, out_ready,
        output filt_ready, if_ready, inpsum_ready,
        output out_valid, out_data, out_filt, out_last, busy, done, err
    );

endinterface

// File: rtl/pe_scratch.sv
// Scratchpad register file: synchronous write, asynchronous read, no reset.
module pe_scratch
    import pe_conv_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_IF_LEN,
    parameter int WIDTH = DEF_DATA_W,
    localparam int AW   = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one word per enabled cycle; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_conv_multifilt.sv
// Multi-filter 1-D convolution PE: loads NUM_FILT filters and one IF row,
// then evaluates every strided window against every filter on one MAC,
// optionally adding an incoming partial sum to each result.
module pe_conv_multifilt
    import pe_conv_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_FILT     = DEF_NUM_FILT,
    parameter int MAX_FILT_LEN = DEF_MAX_FILT_LEN,
    parameter int MAX_IF_LEN   = DEF_MAX_IF_LEN,
    parameter int PSUM_W       = DEF_PSUM_W
) (
    input  logic               clk,
    input  logic               rst,
    pe_conv_multifilt_if.slave bus,
    output state_t             state_o
);
    localparam int FLW    = cnt_w(MAX_FILT_LEN);
    localparam int ILW    = cnt_w(MAX_IF_LEN);
    localparam int FIW    = idx_w(NUM_FILT);
    localparam int FDEPTH = NUM_FILT * MAX_FILT_LEN;
    localparam int FAW    = idx_w(FDEPTH);
    localparam int IAW    = idx_w(MAX_IF_LEN);
    localparam int PW     = 2 * DATA_W;
    localparam int CW     = ILW + 2;

    localparam logic [FLW-1:0] MAX_FL = FLW'(MAX_FILT_LEN);
    localparam logic [ILW-1:0] MAX_IL = ILW'(MAX_IF_LEN);
    localparam logic [FIW-1:0] LAST_F = FIW'(NUM_FILT - 1);

    state_t            state_q, state_d;
    logic [FLW-1:0]    filt_len_q;
    logic [ILW-1:0]    if_len_q, stride_q;
    logic              psum_mode_q;
    logic [FLW-1:0]    k_q, k_d;
    logic [FIW-1:0]    f_q, f_d;
    logic [ILW-1:0]    idx_q, idx_d;
    logic [ILW-1:0]    win_q, win_d;
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic              psum_got_q, psum_got_d;
    logic              err_q, err_d;

    logic              cfg_load, cfg_bad;
    logic              filt_we, if_we;
    logic              filt_ready, if_ready, inpsum_ready, out_valid, done;
    logic [FAW-1:0]    filt_addr;
    logic [IAW-1:0]    if_addr;
    logic [DATA_W-1:0] filt_rd, if_rd;
    logic signed [PW-1:0]     prod;
    logic signed [PSUM_W-1:0] prod_ext;
    logic [ILW:0]      win_next;
    logic              more_win, last_f, last_tap;

    // Filter taps live at f*MAX_FILT_LEN + k; loading and MAC share the address.
    assign filt_addr = FAW'(int'(f_q) * MAX_FILT_LEN + int'(k_q));
    assign if_addr   = (state_q == LOAD_IF) ? IAW'(idx_q) : IAW'(win_q + ILW'(k_q));

    pe_scratch #(.DEPTH(FDEPTH), .WIDTH(DATA_W)) u_filt_mem (
        .clk     (clk),
        .we_i    (filt_we),
        .waddr_i (filt_addr),
        .wdata_i (bus.filt_data),
        .raddr_i (filt_addr),
        .rdata_o (filt_rd)
    );

    pe_scratch #(.DEPTH(MAX_IF_LEN), .WIDTH(DATA_W)) u_if_mem (
        .clk     (clk),
        .we_i    (if_we),
        .waddr_i (if_addr),
        .wdata_i (bus.if_data),
        .raddr_i (if_addr),
        .rdata_o (if_rd)
    );

    // Full-precision signed product, sign-extended into the accumulator width.
    assign prod     = $signed(if_rd) * $signed(filt_rd);
    assign prod_ext = PSUM_W'(prod);

    // Next window start is one bit wider so a large stride cannot wrap.
    assign win_next = {1'b0, win_q} + {1'b0, stride_q};
    assign more_win = (CW'(win_next) + CW'(filt_len_q)) <= CW'(if_len_q);
    assign last_f   = (f_q == LAST_F);
    assign last_tap = (k_q == filt_len_q - FLW'(1));

    assign cfg_bad = (bus.filt_len == '0) || (bus.filt_len > MAX_FL) ||
                     (bus.stride == '0) || (bus.if_len > MAX_IL) ||
                     (bus.if_len < ILW'(bus.filt_len));

    // Next-state, counter and handshake logic for the row sequence.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        f_d          = f_q;
        idx_d        = idx_q;
        win_d        = win_q;
        acc_d        = acc_q;
        psum_got_d   = psum_got_q;
        err_d        = err_q;
        cfg_load     = 1'b0;
        filt_we      = 1'b0;
        if_we        = 1'b0;
        filt_ready   = 1'b0;
        if_ready     = 1'b0;
        inpsum_ready = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cfg_load = 1'b1;
                    err_d    = cfg_bad;
                    k_d      = '0;
                    f_d      = '0;
                    idx_d    = '0;
                    win_d    = '0;
                    acc_d    = '0;
                    state_d  = cfg_bad ? DONE : LOAD_FILT;
                end
            end
            LOAD_FILT: begin
                filt_ready = 1'b1;
                if (bus.filt_valid) begin
                    filt_we = 1'b1;
                    if (last_tap) begin
                        k_d = '0;
                        if (last_f) begin
                            f_d     = '0;
                            state_d = LOAD_IF;
                        end else begin
                            f_d = f_q + FIW'(1);
                        end
                    end else begin
                        k_d = k_q + FLW'(1);
                    end
                end
            end
            LOAD_IF: begin
                if_ready = 1'b1;
                if (bus.if_valid) begin
                    if_we = 1'b1;
                    if (idx_q == if_len_q - ILW'(1)) begin
                        idx_d   = '0;
                        win_d   = '0;
                        f_d     = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end else begin
                        idx_d = idx_q + ILW'(1);
                    end
                end
            end
            MAC: begin
                // The first tap of each (window, filter) restarts the sum.
                acc_d = ((k_q == '0) ? '0 : acc_q) + prod_ext;
                if (last_tap) begin
                    k_d        = '0;
                    psum_got_d = 1'b0;
                    state_d    = EMIT;
                end else begin
                    k_d = k_q + FLW'(1);
                end
            end
            EMIT: begin
                // The partial sum is folded into acc so the result stays put
                // while the output side stalls.
                inpsum_ready = psum_mode_q && !psum_got_q;
                if (inpsum_ready && bus.inpsum_valid) begin
                    acc_d      = acc_q + bus.inpsum_data;
                    psum_got_d = 1'b1;
                end
                out_valid = !psum_mode_q || psum_got_q;
                if (out_valid && bus.out_ready) begin
                    if (!last_f) begin
                        f_d     = f_q + FIW'(1);
                        state_d = MAC;
                    end else begin
                        f_d     = '0;
                        win_d   = win_next[ILW-1:0];
                        state_d = more_win ? MAC : DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, accumulator and latched configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            f_q         <= '0;
            idx_q       <= '0;
            win_q       <= '0;
            acc_q       <= '0;
            psum_got_q  <= 1'b0;
            err_q       <= 1'b0;
            filt_len_q  <= '0;
            if_len_q    <= '0;
            stride_q    <= '0;
            psum_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            f_q        <= f_d;
            idx_q      <= idx_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            psum_got_q <= psum_got_d;
            err_q      <= err_d;
            if (cfg_load) begin
                filt_len_q  <= bus.filt_len;
                if_len_q    <= bus.if_len;
                stride_q    <= bus.stride;
                psum_mode_q <= bus.psum_mode;
            end
        end
    end

    assign bus.filt_ready   = filt_ready;
    assign bus.if_ready     = if_ready;
    assign bus.inpsum_ready = inpsum_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = acc_q;
    assign bus.out_filt     = f_q;
    assign bus.out_last     = (state_q == EMIT) && last_f && !more_win;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done;
    assign bus.err          = err_q;
    assign state_o          = state_q;

endmodule

// File: doc/pe_conv_multifilt.md
# pe_conv_multifilt

Parametrised successor PE for the 1-D convolution accelerator. It loads NUM_FILT signed filters and one signed input-feature (IF) row into internal scratchpads, then computes every strided window against every filter with a single-MAC pipeline. Each result can optionally be added to an incoming partial sum. Results stream out through a valid/ready port to the output buffer, replacing the single-filter, fixed-mode PE datapath in the array.

## Interface
- DATA_W, 8: signed IF and filter element width.
- NUM_FILT, 2: filters held and evaluated per IF row.
- MAX_FILT_LEN, 16: filter scratch depth per filter.
- MAX_IF_LEN, 32: IF scratch depth.
- PSUM_W, 20: accumulator, input-psum and output width; must be ≥ 2*DATA_W + clog2(MAX_FILT_LEN).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches config; ignored unless in IDLE.
- filt_len  in  clog2(MAX_FILT_LEN+1)  taps per filter.
- if_len  in  clog2(MAX_IF_LEN+1)  IF row length.
- stride  in  clog2(MAX_IF_LEN+1)  window step.
- psum_mode  in  1  1 = add one input psum to each result.
- filt_valid / filt_ready  in / out  1  filter load handshake.
- filt_data  in  DATA_W  filter word, filter-major then tap order.
- if_valid / if_ready  in / out  1  IF load handshake.
- if_data  in  DATA_W  IF word in index order.
- inpsum_valid / inpsum_ready  in / out  1  input psum handshake.
- inpsum_data  in  PSUM_W  input psum.
- out_valid / out_ready  out / in  1  result handshake.
- out_data  out  PSUM_W  result.
- out_filt  out  clog2(NUM_FILT)  filter index of out_data.
- out_last  out  1  marks the final result of the row.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of row.
- err  out  1  sticky config error; cleared by next accepted start.

## Operation
- States: IDLE → LOAD_FILT → LOAD_IF → MAC → EMIT → (MAC | DONE) → IDLE.
- IDLE: all ready/valid outputs low. On start, latch config and clear err.
- Config check on start: filt_len==0, filt_len>MAX_FILT_LEN, stride==0, if_len>MAX_IF_LEN, or if_len<filt_len → set err and go to DONE. No words are accepted and no results are emitted.
- LOAD_FILT: filt_ready=1. Each handshake writes one word and advances tap/filter counters. Exactly NUM_FILT*filt_len words are loaded, then the block moves to LOAD_IF.
- LOAD_IF: if_ready=1. Exactly if_len words are loaded, then the block moves to MAC with win=0, f=0.
- MAC: one tap per cycle, filt_len cycles total: acc += sext(if[win+k] * filt[f][k]). The product is a full signed 2*DATA_W value, sign-extended to PSUM_W. acc is cleared at the start of each (win, f).
- EMIT: if psum_mode, inpsum_ready=1 until the handshake, and out_data = acc + inpsum_data. Otherwise out_data = acc. All sums wrap modulo 2^PSUM_W.
- out_valid is raised only once out_data is final. out_data, out_filt and out_last hold stable until out_ready.
- Result order: window-major, filter-minor. After a handshake: if f < NUM_FILT-1, f++ and return to MAC. Otherwise win += stride, f=0; return to MAC if win+filt_len ≤ if_len, else go to DONE.
- out_last=1 only on the last filter of the last window.
- DONE: done=1 for one cycle, then IDLE.

## Timing
- Reset values: every output 0; state IDLE; counters and acc 0. Scratch contents are don't-care.
- Reset mid-operation aborts immediately. No done pulse is produced, and a new start is required.
- Load rate: up to one word per cycle. A stalled valid inserts bubbles and loses nothing.
- Per result: filt_len MAC cycles plus at least 1 EMIT cycle. With out_ready=1 and no psum, the throughput is one result every filt_len+1 cycles.
- First out_valid: filt_len cycles after the last IF handshake.
- start→done with err: exactly 2 cycles (start edge → DONE → pulse).
- start asserted together with done, or while busy, is ignored.

## Structure
- Package pe_conv_pkg holds:
  - state enum (IDLE, LOAD_FILT, LOAD_IF, MAC, EMIT, DONE);
  - default-parameter constants;
  - a width helper function for counters.
- Sub-module pe_scratch: sync-write, async-read register file parametrised by depth and width. It is instantiated for the IF row and for the filters (depth NUM_FILT*MAX_FILT_LEN, addr = f*MAX_FILT_LEN + k).

## Test plan
- All cases use defaults with NUM_FILT=2, filt_len=3, if_len=5, IF=[1,2,3,4,5], F0=[1,0,-1], F1=[1,1,1].
- stride=1, psum_mode=0 → outputs -2,6,-2,9,-2,12 with out_filt 0,1,0,1,0,1; out_last on the 6th; one done pulse.
- stride=2 → -2,6,-2,12; out_last on the 4th.
- psum_mode=1, inpsum=100 each → 98,106,98,109,98,112. Holding inpsum_valid low for 4 cycles delays out_valid accordingly.
- out_ready low for 5 cycles on the 2nd result → out_data=6 and out_filt=1 stay stable; no result is dropped or duplicated.
- Extremes: filt_len=1, IF=-128, filt=-128 → 16384. inpsum=2^19-1 with product 1 → -2^19 (wrap).
- Errors: stride=0 or if_len=2 < filt_len → err=1, done 2 cycles after start, no ready/valid activity.
- rst during MAC → all outputs 0 at once; the next start runs a fresh row correctly.
